sum_accum: RTL
==============

# sum_accum

Downstream consumer of the 3-bit operand adder's 4-bit sum. Collects a fixed number of sums over a valid/ready handshake, accumulates them into a wider total, and presents one result per block with its own valid/ready handshake. It converts the adder's per-operation output into per-block totals for the next stage or for checking.

## Interface
- `IN_W`, 4, width of incoming sum (matches adder output `c`)
- `ACC_W`, 8, accumulator and result width; must be ≥ `IN_W`
- `N`, 4, sums per block; must be ≥ 1; counter width is `$clog2(N+1)`
- `clk`  input  1  single clock; all state updates on rising edge
- `rst_n`  input  1  synchronous, active-low reset
- `in_valid`  input  1  `in_data` valid this cycle
- `in_ready`  output  1  block accepts a sum this cycle
- `in_data`  input  IN_W  unsigned sum from adder
- `out_valid`  output  1  block total available
- `out_ready`  input  1  consumer accepts the total
- `out_data`  output  ACC_W  block total
- `out_ovf`  output  1  an accumulation step in this block overflowed `ACC_W`
- `busy`  output  1  at least one sum accepted in the current block, or a result is pending

## Operation
- Two states:
  - `COLLECT`: `in_ready=1`, `out_valid=0`.
  - `HOLD`: `in_ready=0`, `out_valid=1`.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready`.
- Accept rule: a sum is accepted when `in_valid && in_ready`. On each accept:
  - `acc <= acc + zero_ext(in_data)`, computed in `ACC_W+1` bits.
  - `cnt <= cnt + 1`.
  - If bit `ACC_W` of the sum is set, sticky `ovf <= 1`.
- On the accept where `cnt == N-1`: the final value is written to `acc`, and the state moves to `HOLD`.
- In `HOLD`, `out_data = acc` and `out_ovf = ovf`. Both stay stable until the result is taken. Incoming sums are not accepted in this state.
- Result taken when `out_valid && out_ready` in `HOLD`. Then `acc <= 0`, `cnt <= 0`, `ovf <= 0`, and the state returns to `COLLECT`.
- `in_valid` low in `COLLECT`: no state change. Gaps between sums are allowed.
- In `COLLECT`, `out_data` shows the running `acc` and `out_ovf` shows `ovf`. Both are don't-care to the consumer.
- `busy = (cnt != 0) || (state == HOLD)`.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - Outputs: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_ovf=0`, `busy=0`.
  - Internal: `state=COLLECT`, `cnt=0`, `acc=0`, `ovf=0`.
- Reset mid-block or while in `HOLD` discards the partial or pending total. No result is emitted for that block.
- Latency: `out_valid` rises on the cycle after the edge that accepts the Nth sum.
- Minimum block period is N+1 cycles:
  - N accept cycles.
  - One `HOLD` cycle, when `out_ready` is held high.
  - `in_ready` returns to 1 on the cycle after the handshake.
- `out_ready` asserted before `out_valid` has no effect.
- `in_valid` asserted in `HOLD` is ignored. The upstream holds its data until `in_ready` is seen.
- `N=1`: every accepted sum produces its own result, with `out_data = zero_ext(in_data)`.

## Configuration
- `SUM_ACCUM_SAT_EN` defined:
  - On an overflowing step, `acc` saturates to `{ACC_W{1'b1}}`.
  - It stays saturated for the rest of the block.
  - `out_ovf=1`.
- `SUM_ACCUM_SAT_EN` not defined:
  - `acc` wraps modulo 2^ACC_W.
  - `out_ovf=1` marks that a wrap occurred.
- Handshake and timing are identical in both builds.

## Test plan
- Basic block: N=4, ACC_W=8. Sums 3, 5, 5, 0 on consecutive cycles with `out_ready=1` -> `out_valid` for one cycle, one cycle after the 4th accept, with `out_data=13` and `out_ovf=0`. `in_ready` is high again on the next cycle.
- Backpressure: same stimulus, `out_ready=0` for 5 cycles after `out_valid` rises -> `out_valid=1`, `out_data=13`, `in_ready=0` held for all 5 cycles. Accept occurs on the cycle `out_ready=1`.
- Input gaps: N=4, sums 7, idle, idle, 2, idle, 6, 1 -> single result `out_data=16`, one cycle after the sum 1 is accepted. `busy=1` from the first accept until the handshake.
- Overflow: ACC_W=5, N=4, sums 15, 15, 15, 15 -> `out_ovf=1`. Without the macro, `out_data=28` (60 mod 32). With `SUM_ACCUM_SAT_EN`, `out_data=31`.
- Reset mid-block: N=4. Accept 9 and 4, pulse `rst_n=0` for one cycle, then feed 1, 1, 1, 1 -> result `out_data=4`. All outputs equal their reset values on the cycle after reset.
- N=1: sums 6, 0xF with `out_ready=1` -> two results, 6 then 15. Each appears one cycle after its accept, and accepts are spaced 2 cycles apart.

Source files
------------

// File: rtl/sum_accum_if.sv
// Handshake bundle for sum_accum: sum input stream plus block-total output stream.
interface sum_accum_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/sum_accum.sv
// Accumulates N adder sums per block and hands out one total per block.
// Define SUM_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module sum_accum #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int N     = 4
) (
    input logic        clk,
    input logic        rst_n,
    sum_accum_if.slave bus
);
    localparam int CW  = $clog2(N + 1);
    localparam int PAD = ACC_W + 1 - IN_W;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {{PAD{1'b0}}, bus.in_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        cnt <= cnt + 1'b1;
`ifdef SUM_ACCUM_SAT_EN
                        // once saturated, the block total stays pinned
                        if (sum[ACC_W] || ovf)
                            acc <= '1;
                        else
                            acc <= sum[ACC_W-1:0];
`else
                        acc <= sum[ACC_W-1:0];
`endif
                        if (sum[ACC_W])
                            ovf <= 1'b1;
                        if (cnt == LAST)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
    assign bus.busy      = (cnt != '0) || (state == HOLD);
endmodule
